muldiv_hilo_ctrl: RTL
=====================

// Module: muldiv_hilo_ctrl
// PURPOSE
//  Sequences the multiply/divide unit and owns the HI/LO registers for the 54-instruction CPU.
//  Consumes the one-hot instruction code and register-file operands.
//  Runs multu/mul in one cycle. Runs div/divu through an iterative 32-step divider, stalling the
//  pipeline until the result retires.
//  Serves mfhi/mflo reads and mthi/mtlo writes.
// PARAMETERS
//  DIV_STEPS  32  divider iterations, one quotient bit per cycle (fixed at 32 in this CPU)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  ena        in   1   instruction valid this cycle (same enable as the decoder)
//  code       in   54  one-hot instruction code from the decoder
//  rs_data    in   32  rs operand (dividend/multiplicand, mthi/mtlo source)
//  rt_data    in   32  rt operand (divisor/multiplier)
//  hi_q       out  32  HI register (mfhi data)
//  lo_q       out  32  LO register (mflo data)
//  mul_lo     out  32  combinational low 32 bits of rs*rt, signed, for mul -> rd
//  stall      out  1   hold PC and the instruction register
//  busy       out  1   divider FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, hi_q=lo_q=0, step count=0, stall=0, busy=0.
//   - stall is forced to 0 while rst=1.
//  Opcode bits (from the package):
//   - divu=32, div=33, mul=34, multu=35
//   - mfhi=46, mthi=47, mflo=48, mtlo=49
//  issue = ena & ~rst & state==IDLE.
//  Single-cycle ops, written on the clock edge when issue is high:
//   - multu: {hi,lo} <= rs*rt, unsigned 64-bit.
//   - mthi: hi <= rs.
//   - mtlo: lo <= rs.
//   - mul: HI/LO unchanged; mul_lo is valid in the same cycle.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: on issue with div/divu, latch operands.
//     - For div, latch |rs|, |rt| and both sign bits.
//     - Divisor==0: go to DONE, result lo=32'hFFFF_FFFF, hi=rs, no exception.
//     - Otherwise: go to RUN with count=0.
//   - RUN: one restoring shift-subtract step per cycle; count++.
//     - After step DIV_STEPS-1, go to DONE.
//   - DONE: write hi=remainder, lo=quotient at the end of the cycle; go to IDLE.
//     - The new code seen in DONE (still the same div) is not re-issued.
//  Sign fix for div: quotient negated when the operand signs differ; remainder takes the sign of
//  the dividend.
//   - 0x80000000 / -1 yields lo=0x80000000, hi=0.
//  stall = (issue & (div|divu)) | state==RUN. It is low in DONE, so the instruction retires there.
//  Latency (cycles stall is high):
//   - divu/div with nonzero divisor: 33 (issue cycle + 32 RUN).
//   - divisor zero: 1.
//   - Result is visible on hi_q/lo_q in the first cycle after DONE.
//  Inputs during RUN/DONE:
//   - ena, code and operand changes are ignored (operands were latched).
//   - ena low does not abort; only rst aborts. rst mid-RUN returns to IDLE and clears HI/LO;
//     the partial result is discarded.
//  Simultaneous events: code is one-hot, so at most one op issues per cycle.
//  mfhi/mflo: hi_q/lo_q are plain register outputs, no forwarding.
//   - An mfhi in the instruction after a div sees the new value, because the write happens at the
//     DONE edge.
//  Non-muldiv codes, or code==z while ena=1, change no state.
// STRUCTURE
//  Shared package cpu54_pkg:
//   - opcode bit-index localparams (OP_DIVU..OP_MTLO).
//   - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//  Sub-module div_iter_core:
//   - Holds remainder/quotient shift registers and the 33-bit subtractor.
//   - Ports: clk, rst, load, step, dividend, divisor, quot, rem.
//   - The controller owns the FSM, sign handling and HI/LO.
//  Multiplier: inline combinational; 64-bit unsigned for multu, signed low 32 for mul.
// TESTING
//  1. rst for 2 cycles -> hi_q=lo_q=0, stall=0, busy=0.
//  2. divu rs=100, rt=7 -> stall high for exactly 33 cycles; then lo_q=14, hi_q=2.
//  3. div rs=-7 (0xFFFFFFF9), rt=2 -> lo_q=0xFFFFFFFD, hi_q=0xFFFFFFFF.
//     Also 0x80000000 / -1 -> lo_q=0x80000000, hi_q=0.
//  4. divu rs=5, rt=0 -> stall high for 1 cycle; then lo_q=0xFFFFFFFF, hi_q=5.
//  5. multu 0xFFFFFFFF*0xFFFFFFFF -> next cycle hi_q=0xFFFFFFFE, lo_q=1, stall never high.
//     mul 3*-4 -> mul_lo=0xFFFFFFF4, HI/LO unchanged.
//     mthi 0x1234 then mflo -> hi_q=0x1234 and lo_q unchanged.
//  6. div issued, rst pulsed at RUN step 10 -> IDLE next cycle, HI/LO=0, stall=0.
//     ena toggled low mid-RUN -> completes at cycle 33 with the correct result.

Source files
------------

// File: rtl/cpu54_pkg.sv
// Shared definitions for the 54-instruction CPU: opcode bit positions in the
// one-hot decoder code, and the divider FSM state encoding.
package cpu54_pkg;

   localparam int CODE_W   = 54;
   localparam int OP_DIVU  = 32;
   localparam int OP_DIV   = 33;
   localparam int OP_MUL   = 34;
   localparam int OP_MULTU = 35;
   localparam int OP_MFHI  = 46;
   localparam int OP_MTHI  = 47;
   localparam int OP_MFLO  = 48;
   localparam int OP_MTLO  = 49;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, dividend
// shifts out of the quotient register as quotient bits shift in.
module div_iter_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   logic [31:0] rem_reg;
   logic [31:0] quot_reg;
   logic [31:0] divisor_reg;
   logic [32:0] shifted;
   logic [32:0] diff;

   // rem < divisor always holds, so a non-negative diff never sets bit 32.
   assign shifted = {rem_reg, quot_reg[31]};
   assign diff    = shifted - {1'b0, divisor_reg};

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_reg     <= '0;
         quot_reg    <= '0;
         divisor_reg <= '0;
      end else if (load) begin
         rem_reg     <= '0;
         quot_reg    <= dividend;
         divisor_reg <= divisor;
      end else if (step) begin
         if (!diff[32]) begin
            rem_reg  <= diff[31:0];
            quot_reg <= {quot_reg[30:0], 1'b1};
         end else begin
            rem_reg  <= shifted[31:0];
            quot_reg <= {quot_reg[30:0], 1'b0};
         end
      end
   end

   assign quot = quot_reg;
   assign rem  = rem_reg;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO owner: single-cycle multu/mul/mthi/mtlo,
// iterative div/divu that stalls the pipeline until the result retires.
module muldiv_hilo_ctrl
   import cpu54_pkg::*;
#(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [53:0] code,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q,
   output logic [31:0] mul_lo,
   output logic        stall,
   output logic        busy
);

   localparam int CNT_W = $clog2(DIV_STEPS);

   div_state_t       state_reg, state_next;
   logic [CNT_W-1:0] count_reg;
   logic [31:0]      hi_reg, lo_reg;
   logic [31:0]      rs_raw_reg;
   logic             sign_q_reg, sign_r_reg, zero_div_reg;

   logic        issue, is_div, is_divu, div_issue, last_step;
   logic [31:0] dividend_in, divisor_in;
   logic [31:0] core_quot, core_rem;
   logic [31:0] quot_fix, rem_fix;
   logic [63:0] multu_prod;
   logic        unused_code;

   assign issue     = ena & ~rst & (state_reg == IDLE);
   assign is_div    = code[OP_DIV];
   assign is_divu   = code[OP_DIVU];
   assign div_issue = issue & (is_div | is_divu);
   assign last_step = (count_reg == CNT_W'(DIV_STEPS - 1));

   // mfhi/mflo need no action here: HI/LO are read straight off hi_q/lo_q.
   assign unused_code = ^{code[53:50], code[OP_MFHI], code[OP_MFLO], code[45:36], code[31:0]};

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (div_issue) state_next = (rt_data == 32'd0) ? DONE : RUN;
         RUN:  if (last_step) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign dividend_in = is_div ? abs32(rs_data) : rs_data;
   assign divisor_in  = is_div ? abs32(rt_data) : rt_data;

   div_iter_core u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (div_issue),
      .step     (state_reg == RUN),
      .dividend (dividend_in),
      .divisor  (divisor_in),
      .quot     (core_quot),
      .rem      (core_rem)
   );

   assign quot_fix = sign_q_reg ? neg32(core_quot) : core_quot;
   assign rem_fix  = sign_r_reg ? neg32(core_rem)  : core_rem;

   assign multu_prod = {32'd0, rs_data} * {32'd0, rt_data};
   assign mul_lo     = $signed(rs_data) * $signed(rt_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_reg       <= '0;
         lo_reg       <= '0;
         count_reg    <= '0;
         rs_raw_reg   <= '0;
         sign_q_reg   <= 1'b0;
         sign_r_reg   <= 1'b0;
         zero_div_reg <= 1'b0;
      end else begin
         if (div_issue) begin
            rs_raw_reg   <= rs_data;
            sign_q_reg   <= is_div & (rs_data[31] ^ rt_data[31]);
            sign_r_reg   <= is_div & rs_data[31];
            zero_div_reg <= (rt_data == 32'd0);
            count_reg    <= '0;
         end else if (state_reg == RUN) begin
            count_reg <= count_reg + CNT_W'(1);
         end

         // Zero divisor bypasses RUN: all-ones quotient, untouched dividend in HI.
         if (state_reg == DONE) begin
            hi_reg <= zero_div_reg ? rs_raw_reg   : rem_fix;
            lo_reg <= zero_div_reg ? 32'hFFFF_FFFF : quot_fix;
         end else if (issue) begin
            if (code[OP_MULTU]) begin
               hi_reg <= multu_prod[63:32];
               lo_reg <= multu_prod[31:0];
            end
            if (code[OP_MTHI]) hi_reg <= rs_data;
            if (code[OP_MTLO]) lo_reg <= rs_data;
         end
      end
   end

   assign hi_q  = hi_reg;
   assign lo_q  = lo_reg;
   assign stall = ~rst & (div_issue | (state_reg == RUN));
   assign busy  = (state_reg != IDLE);

endmodule
